run_pattern_tx: RTL

RUN_PATTERN_TX -- requirements
Module: run_pattern_tx

---
 rtl/run_pattern_tx_pkg.sv | 19 +
 rtl/run_pattern_tx_load_down_counter.sv | 36 +++
 rtl/run_pattern_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/run_pattern_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_pattern_tx_pkg : state encodings, field-width defaults, state type |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package run_pattern_tx_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int REP_W_DEF = 3;

  // Plain vector type so the illegal 2'b11 encoding stays representable
  typedef logic [1:0] state_t;

  localparam state_t c_IDLE = 2'b00;
  localparam state_t c_RUN  = 2'b01;
  localparam state_t c_TERM = 2'b10;

endpackage
`default_nettype wire

// File: rtl/run_pattern_tx_load_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_down_counter : loadable down counter that saturates at zero      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module load_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count   = r_count;
  assign is_one  = (r_count == WIDTH'(1));
  assign is_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/run_pattern_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_pattern_tx : serial (repeat_count+1) x (run_len ones + one zero)  |
// | burst pattern generator. Revision 1.0                                 |
// +----------------------------------------------------------------------+
module run_pattern_tx
  import run_pattern_tx_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  input  logic [LEN_W-1:0] run_len,
  input  logic [REP_W-1:0] repeat_count,
  output logic             start_ready,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       out_state
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_bit_cnt;
  logic [LEN_W-1:0] w_bit_val;
  logic [REP_W-1:0] w_burst_cnt;
  logic             w_bit_one, w_bit_zero, w_burst_one, w_burst_zero;
  logic             w_handshake, w_bit_load, w_bit_dec, w_burst_dec;
  logic             w_unused;

  assign w_handshake = (r_state == c_IDLE) && start_valid;
  // Bit counter reloads on handshake and at every non-final terminator
  assign w_bit_load  = w_handshake || ((r_state == c_TERM) && !w_burst_zero);
  assign w_bit_val   = w_handshake ? run_len : r_len;
  assign w_bit_dec   = (r_state == c_RUN) && !w_bit_one && !w_bit_zero;
  assign w_burst_dec = (r_state == c_TERM) && !w_burst_zero;

  load_down_counter #(.WIDTH(LEN_W)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_bit_load),
    .load_val (w_bit_val),
    .dec      (w_bit_dec),
    .count    (w_bit_cnt),
    .is_one   (w_bit_one),
    .is_zero  (w_bit_zero)
  );

  load_down_counter #(.WIDTH(REP_W)) u_burst_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_handshake),
    .load_val (repeat_count),
    .dec      (w_burst_dec),
    .count    (w_burst_cnt),
    .is_one   (w_burst_one),
    .is_zero  (w_burst_zero)
  );

  // Counter outputs this block has no use for
  assign w_unused = ^{w_bit_cnt, w_burst_cnt, w_burst_one};

  always_comb begin
    w_next = c_IDLE;
    case (r_state)
      c_IDLE: begin
        if (start_valid) w_next = (run_len != '0) ? c_RUN : c_TERM;
        else             w_next = c_IDLE;
      end
      c_RUN: begin
        w_next = (w_bit_one || w_bit_zero) ? c_TERM : c_RUN;
      end
      c_TERM: begin
        if (w_burst_zero)     w_next = c_IDLE;
        else if (r_len != '0) w_next = c_RUN;
        else                  w_next = c_TERM;
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (w_handshake) r_len <= run_len;
    end
  end

  assign start_ready = (r_state == c_IDLE);
  assign out         = (r_state == c_RUN);
  assign busy        = (r_state == c_RUN) || (r_state == c_TERM);
  assign done        = (r_state == c_TERM) && w_burst_zero;
  assign out_state   = r_state;

endmodule
`default_nettype wire
